fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Control block for the in-place, memory-based radix-2 DIT 64-point FFT core.
- Accepts one 64-sample frame and generates bit-reversed write addresses for the load.
- Sequences six butterfly stages of 32 butterflies each, producing read/write addresses, twiddle indices and ping-pong bank selects.
- Pulses `dataind` to the output counter when the transformed frame is complete.

Parameters:
- PIPE_LAT, 4: butterfly datapath latency in cycles; drain gap inserted after each stage (legal range 1..15).
- N_LOG2, 6: log2 of transform size; fixed at 6 for this core (64 points, 32 butterflies per stage).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input sample present on datapath this cycle.
- in_ready  output  1  sequencer accepts a sample this cycle; registered.
- ld_we  output  1  write strobe to sample RAM bank 0 for the current load sample.
- ld_addr  output  6  bit-reversed load address.
- bf_valid  output  1  butterfly issue strobe.
- addr_a  output  6  butterfly upper-operand address.
- addr_b  output  6  butterfly lower-operand address.
- tw_addr  output  5  twiddle ROM index.
- rd_bank  output  1  RAM bank read by the current stage.
- wr_bank  output  1  RAM bank written by the current stage.
- stage_o  output  3  current stage number, 0..5.
- busy  output  1  high from first accepted sample until `dataind` pulses.
- dataind  output  1  one-cycle frame-complete pulse to the output counter.

Behaviour:
- All outputs are registered. Synchronous active-high reset; `rst` sampled on the rising edge of `clk`.
- Reset values: state IDLE; all outputs 0; load counter 0; stage 0; butterfly counter 0; drain counter 0. `in_ready` rises to 1 on the first clock after `rst` deasserts.
- Acceptance: a sample is accepted on any edge where `in_valid` = 1 and `in_ready` = 1.
- State IDLE:
  - `in_ready` = 1.
  - On acceptance: `ld_we` = 1, `ld_addr` = bitrev(0) = 0, load counter goes to 1, `busy` = 1, go to LOAD.
- State LOAD:
  - On each acceptance: `ld_we` = 1, `ld_addr` = bitrev6(counter), counter increments.
  - `ld_we` = 0 on cycles without acceptance.
  - On accepting sample 63: `in_ready` = 0, go to COMPUTE with stage 0 and k = 0.
- State COMPUTE (stage s, butterfly k = 0..31):
  - One butterfly is issued per cycle; `bf_valid` = 1.
  - Address generation:
    - grp = k >> s, pos = k & (2^s − 1).
    - `addr_a` = (grp << (s+1)) | pos.
    - `addr_b` = `addr_a` + 2^s.
    - `tw_addr` = pos << (5 − s).
  - Bank selects: `rd_bank` = s[0], `wr_bank` = ~s[0]. `stage_o` = s.
  - After issuing k = 31, go to DRAIN.
- State DRAIN:
  - `bf_valid` = 0 for exactly PIPE_LAT cycles; addresses hold their last values.
  - Then, if s < 5: s increments, k = 0, return to COMPUTE.
  - If s = 5: go to DONE.
- State DONE:
  - `dataind` = 1 for exactly one cycle; `busy` = 0 in the same cycle.
  - Next state IDLE, with `in_ready` = 1 the following cycle.
  - Result resides in bank 0 (the stage 5 write bank).
- In-flight frames: during COMPUTE/DRAIN/DONE, `in_ready` = 0 and `in_valid` is ignored. A new frame is never overlapped or partially accepted.
- Frame latency with no input stalls: 64 load cycles, then 6 × (32 + PIPE_LAT) compute/drain cycles, then `dataind` on the next cycle. With PIPE_LAT = 4: `dataind` is high 216 cycles after the edge that accepted sample 63.
- Arithmetic: all address arithmetic is modulo-free by construction (`addr_b` ≤ 63, `tw_addr` ≤ 31). Counters are sized exactly (6-bit load, 5-bit k, 3-bit stage, 4-bit drain) and never wrap except load counter 63 → 0 on exit from LOAD.
- Reset mid-operation: state and counters return to reset values on the next edge regardless of state. A partially loaded or partially computed frame is discarded and no `dataind` is produced.
- `in_valid` de-asserted mid-load: sequencer stays in LOAD indefinitely; there is no timeout.

Test Plan:
- Reset then 64 back-to-back samples → `ld_addr` sequence 0, 32, 16, 48, 8, …, 63. `in_ready` falls the cycle after sample 63. `busy` = 1 throughout the frame.
- Stage 0 issue → k = 0..31 gives (`addr_a`, `addr_b`) = (0,1), (2,3), …, (62,63); `tw_addr` = 0 throughout; `rd_bank` = 0, `wr_bank` = 1.
- Stage 3 check → k = 5 gives `addr_a` = 5, `addr_b` = 13, `tw_addr` = 20. Stage 5, k = 31 gives `addr_a` = 31, `addr_b` = 63, `tw_addr` = 31; `rd_bank` = 1, `wr_bank` = 0.
- Full frame, PIPE_LAT = 4 → exactly 4 `bf_valid`-low cycles between stages. 192 total `bf_valid` cycles. Single `dataind` pulse 216 cycles after the last sample. `in_ready` back to 1 the cycle after.
- `in_valid` toggled 1/0 during load and asserted during COMPUTE → load addresses advance only on acceptance; no extra `ld_we`; no effect during compute.
- `rst` asserted at stage 2, k = 10, and again at load sample 40 → all outputs 0 next cycle; no `dataind`. A subsequent clean frame completes normally.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: load/butterfly/drain sequencing for an in-place radix-2 DIT 64-point FFT.
module fft_stage_sequencer #(
  parameter int PIPE_LAT = 4,
  parameter int N_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ld_we,
  output logic [5:0] ld_addr,
  output logic       bf_valid,
  output logic [5:0] addr_a,
  output logic [5:0] addr_b,
  output logic [4:0] tw_addr,
  output logic       rd_bank,
  output logic       wr_bank,
  output logic [2:0] stage_o,
  output logic       busy,
  output logic       dataind
);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
  localparam logic [5:0] LAST_LD = 6'((1 << N_LOG2) - 1);
  localparam logic [2:0] LAST_ST = 3'(N_LOG2 - 1);
  localparam logic [3:0] LAST_DR = 4'(PIPE_LAT - 1);
  state_t state, state_n;
  logic [5:0] ld_cnt, ld_cnt_n;
  logic [2:0] s, s_n;
  logic [4:0] k, k_n;
  logic [3:0] d, d_n;
  logic in_ready_n, ld_we_n, bf_valid_n, rd_bank_n, wr_bank_n, busy_n, dataind_n;
  logic [5:0] ld_addr_n, addr_a_n, addr_b_n;
  logic [4:0] tw_addr_n;
  logic [2:0] stage_n;
  logic [5:0] k6, mask, pos, a, b, br;
  logic [4:0] tw;
  logic acc;
  // Butterfly k of stage s: k's low s bits stay put, the upper bits move up one to open the bit-s slot.
  assign k6 = {1'b0, k};
  assign mask = ~(6'h3f << s);
  assign pos = k6 & mask;
  assign a = ((k6 & ~mask) << 1) | pos;
  assign b = a | (6'd1 << s);
  assign tw = 5'(pos << (3'd5 - s));
  assign br = {ld_cnt[0], ld_cnt[1], ld_cnt[2], ld_cnt[3], ld_cnt[4], ld_cnt[5]};
  assign acc = in_valid & in_ready;
  always_comb begin
    state_n = state;
    ld_cnt_n = ld_cnt;
    s_n = s;
    k_n = k;
    d_n = d;
    in_ready_n = in_ready;
    ld_we_n = 1'b0;
    ld_addr_n = ld_addr;
    bf_valid_n = 1'b0;
    addr_a_n = addr_a;
    addr_b_n = addr_b;
    tw_addr_n = tw_addr;
    rd_bank_n = rd_bank;
    wr_bank_n = wr_bank;
    stage_n = stage_o;
    busy_n = busy;
    dataind_n = 1'b0;
    case (state)
      IDLE, LOAD: begin
        in_ready_n = 1'b1;
        if (acc) begin
          ld_we_n = 1'b1;
          ld_addr_n = br;
          ld_cnt_n = ld_cnt + 6'd1;
          busy_n = 1'b1;
          state_n = LOAD;
          if (ld_cnt == LAST_LD) begin
            in_ready_n = 1'b0;
            state_n = COMPUTE;
            s_n = '0;
            k_n = '0;
          end
        end
      end
      COMPUTE: begin
        bf_valid_n = 1'b1;
        addr_a_n = a;
        addr_b_n = b;
        tw_addr_n = tw;
        rd_bank_n = s[0];
        wr_bank_n = ~s[0];
        stage_n = s;
        k_n = k + 5'd1;
        state_n = (k == 5'd31) ? DRAIN : COMPUTE;
      end
      DRAIN: begin
        d_n = d + 4'd1;
        if (d == LAST_DR) begin
          d_n = '0;
          k_n = '0;
          if (s == LAST_ST) begin
            state_n = DONE;
            dataind_n = 1'b1;
            busy_n = 1'b0;
          end else begin
            s_n = s + 3'd1;
            state_n = COMPUTE;
          end
        end
      end
      DONE: begin
        in_ready_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ld_cnt <= '0;
      s <= '0;
      k <= '0;
      d <= '0;
      in_ready <= 1'b0;
      ld_we <= 1'b0;
      ld_addr <= '0;
      bf_valid <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      tw_addr <= '0;
      rd_bank <= 1'b0;
      wr_bank <= 1'b0;
      stage_o <= '0;
      busy <= 1'b0;
      dataind <= 1'b0;
    end else begin
      state <= state_n;
      ld_cnt <= ld_cnt_n;
      s <= s_n;
      k <= k_n;
      d <= d_n;
      in_ready <= in_ready_n;
      ld_we <= ld_we_n;
      ld_addr <= ld_addr_n;
      bf_valid <= bf_valid_n;
      addr_a <= addr_a_n;
      addr_b <= addr_b_n;
      tw_addr <= tw_addr_n;
      rd_bank <= rd_bank_n;
      wr_bank <= wr_bank_n;
      stage_o <= stage_n;
      busy <= busy_n;
      dataind <= dataind_n;
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of load order, butterfly addressing, drain gaps, dataind timing and reset.
module tb_fft_stage_sequencer;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic in_ready, ld_we, bf_valid, rd_bank, wr_bank, busy, dataind;
  logic [5:0] ld_addr, addr_a, addr_b;
  logic [4:0] tw_addr;
  logic [2:0] stage_o;
  int checks = 0, errors = 0;
  int cnt, idx, low, done_n, stray, st, kk;
  logic hit, seen;
  fft_stage_sequencer #(.PIPE_LAT(4), .N_LOG2(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ld_we(ld_we),
    .ld_addr(ld_addr), .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b),
    .tw_addr(tw_addr), .rd_bank(rd_bank), .wr_bank(wr_bank), .stage_o(stage_o),
    .busy(busy), .dataind(dataind)
  );
  always #5 clk = ~clk;
  function automatic logic [5:0] br(input int v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_ld_we"}, ld_we, 0);
    chk({tag, "_ld_addr"}, ld_addr, 0);
    chk({tag, "_bf_valid"}, bf_valid, 0);
    chk({tag, "_addr_a"}, addr_a, 0);
    chk({tag, "_addr_b"}, addr_b, 0);
    chk({tag, "_tw"}, tw_addr, 0);
    chk({tag, "_stage"}, stage_o, 0);
    chk({tag, "_banks"}, {rd_bank, wr_bank}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dataind"}, dataind, 0);
  endtask
  task automatic load_full();
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("load_we", ld_we, 1);
      chk("load_addr", ld_addr, br(i));
      chk("load_busy", busy, 1);
      chk("load_ready", in_ready, i < 63);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    chk("idle_busy", busy, 0);
    // Toggled in_valid: only accepted samples advance the bit-reversed address.
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 40; i++) begin
      in_valid = (i % 2 == 0);
      @(negedge clk);
      if (in_valid) begin
        chk("tog_we", ld_we, 1);
        chk("tog_addr", ld_addr, br(cnt));
        cnt++;
      end else chk("tog_no_we", ld_we, 0);
    end
    chk("tog_count", cnt, 40);
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk_zero("rst_load");
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst_load", in_ready, 1);
    // Clean load, then reset at stage 2, k = 10 (addr_a 18).
    load_full();
    in_valid = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      if (bf_valid && stage_o == 3'd2 && addr_a == 6'd18) hit = 1'b1;
    end
    chk("hit_s2k10", hit, 1);
    chk("s2k10_addr_b", addr_b, 22);
    chk("s2k10_tw", tw_addr, 16);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_compute");
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (dataind || bf_valid) seen = 1'b1;
    end
    chk("no_dataind_after_abort", seen, 0);
    chk("idle_ready_after_abort", in_ready, 1);
    // Full frame with in_valid toggling during compute.
    load_full();
    idx = 0;
    low = 0;
    done_n = -1;
    stray = 0;
    for (int n = 1; n <= 300 && done_n < 0; n++) begin
      in_valid = n[0];
      @(negedge clk);
      if (dataind) done_n = n;
      if (ld_we || in_ready || (!dataind && !busy)) stray++;
      if (bf_valid) begin
        st = idx / 32;
        kk = idx % 32;
        if (idx > 0 && kk == 0) chk("drain_gap", low, 4);
        low = 0;
        chk("stage", stage_o, st);
        chk("rd_bank", rd_bank, st % 2);
        chk("wr_bank", wr_bank, 1 - st % 2);
        chk("addr_b_span", addr_b - addr_a, 1 << st);
        if (st == 0) begin
          chk("s0_addr_a", addr_a, 2 * kk);
          chk("s0_addr_b", addr_b, 2 * kk + 1);
          chk("s0_tw", tw_addr, 0);
        end
        if (st == 3 && kk == 5) begin
          chk("s3k5_addr_a", addr_a, 5);
          chk("s3k5_addr_b", addr_b, 13);
          chk("s3k5_tw", tw_addr, 20);
        end
        if (st == 5 && kk == 31) begin
          chk("s5k31_addr_a", addr_a, 31);
          chk("s5k31_addr_b", addr_b, 63);
          chk("s5k31_tw", tw_addr, 31);
        end
        idx++;
      end else low++;
    end
    chk("dataind_latency", done_n, 216);
    chk("bf_total", idx, 192);
    chk("compute_stray", stray, 0);
    chk("done_busy", busy, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("dataind_one_cycle", dataind, 0);
    chk("ready_after_done", in_ready, 1);
    chk("busy_after_done", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
